// File: rtl/display_scheduler.sv
// display_scheduler: round-robin owner of the 8-digit display. Holds each winner
// for a dwell period and converts its value to packed BCD by sequential double-dabble.
module display_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NUM_REQ-1:0]    Req,
    input  logic [32*NUM_REQ-1:0] Values,
    output logic [NUM_REQ-1:0]    Grant,
    output logic [31:0]           Digits,
    output logic                  Update,
    output logic                  Overflow,
    output logic                  Busy
);
    // state   | meaning
    // IDLE    | no owner; display keeps its last value
    // CONVERT | double-dabble of the captured value, one bit per cycle, MSB first
    // HOLD    | owner shown until the dwell counter expires, then re-arbitrate

    localparam int          IDXW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

    state_t          state, state_next;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] winner;
    logic            found;
    logic [31:0]     capture;
    logic [31:0]     dwell;
    logic [4:0]      bit_cnt;
    logic [39:0]     scratch, scratch_adj, scratch_next;
    logic            arb;
    logic            conv_done;
    logic            too_big;

    // First requesting index at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin : arb_search
        int idx;
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && Req[IDXW'(idx)]) begin
                found  = 1'b1;
                winner = IDXW'(idx);
            end
        end
    end

    always_comb begin
        scratch_adj = scratch;
        for (int n = 0; n < 10; n++) begin
            if (scratch[4*n +: 4] >= 4'd5) scratch_adj[4*n +: 4] = scratch[4*n +: 4] + 4'd3;
        end
        scratch_next = {scratch_adj[38:0], capture[5'd31 - bit_cnt]};
        // Any digit above the eighth means the value does not fit the display.
        too_big = |{scratch_adj[39], scratch_next[39:32]};
    end

    always_comb begin
        state_next = state;
        arb        = 1'b0;
        conv_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    arb        = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (bit_cnt == 5'd31) begin
                    conv_done  = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (dwell == DWELL_LAST) begin
                    arb        = 1'b1;
                    state_next = found ? CONVERT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr      <= '0;
            Grant    <= '0;
            capture  <= '0;
            scratch  <= '0;
            bit_cnt  <= '0;
            dwell    <= '0;
            Digits   <= '1;
            Update   <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Update <= conv_done;
            if (state == CONVERT) begin
                scratch <= scratch_next;
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (arb) begin
                if (found) begin
                    capture <= Values[32*int'(winner) +: 32];
                    Grant   <= NUM_REQ'(1) << winner;
                    ptr     <= (winner == IDXW'(NUM_REQ - 1)) ? '0 : winner + IDXW'(1);
                    scratch <= '0;
                    bit_cnt <= '0;
                end else begin
                    Grant <= '0;
                end
            end
            if (conv_done) begin
                Digits   <= too_big ? 32'hFFFF_FFFF : scratch_next[31:0];
                Overflow <= too_big;
                dwell    <= '0;
            end else if (state == HOLD) begin
                dwell <= dwell + 32'd1;
            end
        end
    end

    assign Busy = (state == CONVERT);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus randomized rounds, checked
// against a transaction-level model (round-robin pick, decimal digits by arithmetic).
module tb_display_scheduler;
    localparam int N = 4;
    localparam int D = 10;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic [N-1:0]    Req;
    logic [32*N-1:0] Values;
    logic [N-1:0]    Grant;
    logic [31:0]     Digits;
    logic            Update;
    logic            Overflow;
    logic            Busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          m_ptr = 0;
    int          prev_cap = 0;
    logic [31:0] last_digits = 32'hFFFF_FFFF;
    logic        last_ovf = 1'b0;
    logic [N-1:0] cur_req = '0;
    logic [31:0] cur_vals [N];

    display_scheduler #(.NUM_REQ(N), .DWELL_CYCLES(D)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Values(Values), .Grant(Grant),
        .Digits(Digits), .Update(Update), .Overflow(Overflow), .Busy(Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] to_bcd(input logic [31:0] v);
        logic [31:0] r;
        longint      x;
        r = '0;
        x = longint'(v);
        if (v >= 32'd100000000) return 32'hFFFF_FFFF;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
        for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0: return 32'd99999999;
            1: return 32'd100000000;
            2: return 32'd0;
            3: return 32'hFFFF_FFFF;
            4: return $urandom;
            default: return 32'($urandom_range(0, 99999999));
        endcase
    endfunction

    task automatic apply_inputs();
        Req = cur_req;
        for (int i = 0; i < N; i++) Values[32*i +: 32] = cur_vals[i];
    endtask

    // Caller has applied inputs at a negedge; the next arbitration should capture.
    task automatic expect_capture(input bit from_hold);
        int          w;
        int          waited;
        int          busy_n;
        bit          upd_seen;
        logic [31:0] val;
        logic [31:0] exp_d;
        w = rr_pick(m_ptr, cur_req);
        if (w < 0) return;
        val = cur_vals[w];
        m_ptr = (w + 1) % N;
        waited = 0;
        while (Busy !== 1'b1 && waited < 60) begin
            @(negedge Clk);
            waited++;
        end
        check("capture_seen", 32'(Busy === 1'b1), 32'd1);
        if (Busy !== 1'b1) return;
        check("grant", 32'(Grant), 32'(1) << w);
        if (from_hold) check("interval", 32'(cyc - prev_cap), 32'(D + 32));
        prev_cap = cyc;
        busy_n = 0;
        upd_seen = 1'b0;
        while (Busy === 1'b1 && busy_n < 40) begin
            if (Update !== 1'b0) upd_seen = 1'b1;
            busy_n++;
            Req = N'($urandom);
            for (int i = 0; i < N; i++) Values[32*i +: 32] = $urandom;
            @(negedge Clk);
        end
        check("busy_cycles", 32'(busy_n), 32'd32);
        check("update_in_busy", 32'(upd_seen), 32'd0);
        apply_inputs();
        exp_d = to_bcd(val);
        check("digits", Digits, exp_d);
        check("overflow", 32'(Overflow), 32'(val >= 32'd100000000));
        check("update_pulse", 32'(Update), 32'd1);
        check("grant_hold", 32'(Grant), 32'(1) << w);
        @(negedge Clk);
        check("update_clear", 32'(Update), 32'd0);
        last_digits = exp_d;
        last_ovf = (val >= 32'd100000000);
    endtask

    task automatic expect_release();
        bit upd;
        bit bsy;
        upd = 1'b0;
        bsy = 1'b0;
        cur_req = '0;
        apply_inputs();
        for (int i = 0; i < D + 4; i++) begin
            @(negedge Clk);
            if (Update !== 1'b0) upd = 1'b1;
            if (Busy !== 1'b0) bsy = 1'b1;
        end
        check("idle_grant", 32'(Grant), 32'd0);
        check("idle_digits", Digits, last_digits);
        check("idle_overflow", 32'(Overflow), 32'(last_ovf));
        check("idle_no_update", 32'(upd), 32'd0);
        check("idle_no_busy", 32'(bsy), 32'd0);
    endtask

    initial begin
        logic [31:0] bounds [4];
        bit          in_idle;
        int          waited;
        bit          upd;
        bounds[0] = 32'd99999999;
        bounds[1] = 32'd100000000;
        bounds[2] = 32'd0;
        bounds[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) cur_vals[i] = $urandom;
        cur_req = '0;
        apply_inputs();

        repeat (3) @(negedge Clk);
        check("rst_grant", 32'(Grant), 32'd0);
        check("rst_digits", Digits, 32'hFFFF_FFFF);
        check("rst_update", 32'(Update), 32'd0);
        check("rst_overflow", 32'(Overflow), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);
        check("idle_noreq_busy", 32'(Busy), 32'd0);
        check("idle_noreq_grant", 32'(Grant), 32'd0);

        // Single requester, then value boundaries through requester 0.
        cur_vals[0] = 32'd12345678;
        cur_req = 4'b0001;
        apply_inputs();
        expect_capture(1'b0);
        for (int b = 0; b < 4; b++) begin
            cur_vals[0] = bounds[b];
            apply_inputs();
            expect_capture(1'b1);
        end

        // Round-robin over a fixed request set with distinct values.
        cur_req = 4'b1011;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < N; i++) cur_vals[i] = 32'(1000 * (r + 1) + 111 * i);
            apply_inputs();
            expect_capture(1'b1);
        end

        // Release during HOLD, then a fresh request from IDLE.
        expect_release();
        cur_vals[2] = 32'd87654321;
        cur_req = 4'b0100;
        apply_inputs();
        expect_capture(1'b0);

        in_idle = 1'b0;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) cur_vals[i] = rand_val();
            cur_req = N'($urandom_range(0, (1 << N) - 1));
            if (cur_req == '0) begin
                if (!in_idle) expect_release();
                in_idle = 1'b1;
            end else begin
                apply_inputs();
                expect_capture(!in_idle);
                in_idle = 1'b0;
            end
        end

        // Reset in the middle of a conversion.
        cur_vals[0] = 32'd42;
        cur_req = 4'b0001;
        apply_inputs();
        expect_capture(!in_idle);
        cur_vals[0] = 32'd555;
        apply_inputs();
        waited = 0;
        while (Busy !== 1'b1 && waited < 60) begin
            @(negedge Clk);
            waited++;
        end
        repeat (15) @(negedge Clk);
        check("pre_reset_busy", 32'(Busy), 32'd1);
        check("pre_reset_digits", Digits, 32'h0000_0042);
        Rst_n = 1'b0;
        #1;
        check("async_rst_digits", Digits, 32'hFFFF_FFFF);
        check("async_rst_grant", 32'(Grant), 32'd0);
        check("async_rst_busy", 32'(Busy), 32'd0);
        upd = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            if (Update !== 1'b0) upd = 1'b1;
        end
        check("rst_no_update", 32'(upd), 32'd0);
        m_ptr = 0;
        last_digits = 32'hFFFF_FFFF;
        last_ovf = 1'b0;
        for (int i = 0; i < N; i++) cur_vals[i] = 32'(2000 + i);
        cur_req = 4'b1111;
        apply_inputs();
        Rst_n = 1'b1;
        expect_capture(1'b0);
        expect_capture(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Shares the 8-digit seven-segment display among up to NUM_REQ requesters (e.g. PC, ALU result, register debug taps).
- Arbitrates round-robin and holds each winner on the display for a minimum dwell time.
- Converts the winner's 32-bit binary value to 8 packed BCD digits with a sequential shift-add-3 (double-dabble) engine, so the display driver no longer needs combinational divide/modulo.
- Sits between the processor debug sources and the display driver's digit inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DWELL_CYCLES, 100000000, Clk cycles a grant is held before re-arbitration (1 s at 100 MHz); minimum 2

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  reset, asynchronous, active-low
Req  input  NUM_REQ  per-requester display request, level-sensitive
Values  input  32*NUM_REQ  requester i value in bits [32*i+31:32*i], unsigned binary
Grant  output  NUM_REQ  one-hot index of the requester currently shown; 0 when none
Digits  output  32  packed BCD; [3:0] is the ones digit, [31:28] is the ten-millions digit; 4'hF means blank
Update  output  1  one-cycle pulse when Digits changes
Overflow  output  1  high while the displayed value is >= 100000000
Busy  output  1  high in CONVERT

Behaviour:
- Reset values (async on Rst_n=0): state IDLE; Grant=0; Digits=32'hFFFF_FFFF; Update=0; Overflow=0; Busy=0; dwell counter=0; round-robin pointer at requester 0, so requester 0 has highest priority first.
- States: IDLE, CONVERT, HOLD.
- IDLE, no Req bit set: stay in IDLE; outputs unchanged. Digits keep the last display.
- IDLE, any Req bit set:
  - Pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - On that edge: latch its Values slice into the capture register, set Grant one-hot, set the pointer to winner+1 (mod NUM_REQ), and go to CONVERT.
- CONVERT: 32 iterations, one input bit per cycle, MSB first.
  - Each cycle, add 3 to every 4-bit BCD nibble >= 5 in a 40-bit scratch (10 digits), then shift left by 1 bringing in the next bit.
  - On the edge ending the 32nd CONVERT cycle:
    - Digits = scratch[31:0], or 32'hFFFF_FFFF if the captured value >= 100000000.
    - Overflow set to match.
    - Update=1 for exactly the next cycle.
    - Dwell counter cleared; go to HOLD.
  - Latency from the capture edge to Digits valid is 32 edges.
  - Values and Req are ignored during CONVERT; the captured value is used.
- HOLD: the dwell counter increments each cycle. When it reaches DWELL_CYCLES-1, re-arbitrate using the IDLE rule on the current Req:
  - Winner found, including the same requester if it is the only one: recapture, go to CONVERT. Grant may stay the same index.
  - No Req: go to IDLE. Grant=0; Digits and Overflow retained.
- Req deassert mid-CONVERT or mid-HOLD: the current conversion and dwell complete normally, with no early abort.
- Busy = (state==CONVERT). Update never asserts outside the cycle after CONVERT completes.
- Boundaries:
  - Value 0 gives Digits 32'h0000_0000; no leading-zero blanking.
  - 99999999 gives 32'h9999_9999, Overflow=0.
  - 100000000 and 32'hFFFF_FFFF give blank, Overflow=1.
- Pointer wrap: winner NUM_REQ-1 sets the pointer to 0.
- Reset asserted mid-CONVERT or mid-HOLD: immediate return to reset values, with no partial Digits update. After release, the first grant restarts at requester 0.

Test Plan:
1. DWELL_CYCLES=10; Req=4'b0001, Values[31:0]=12345678 → Grant=4'b0001 after capture edge; 32 edges later Digits=32'h1234_5678, Update one-cycle pulse, Overflow=0, Busy high exactly 32 cycles.
2. Value boundaries via requester 0:
   - 99999999 → 32'h9999_9999, Overflow=0.
   - 100000000 → 32'hFFFF_FFFF, Overflow=1.
   - 0 → 32'h0000_0000.
   - 32'hFFFF_FFFF → blank, Overflow=1.
3. Round-robin: DWELL_CYCLES=10, Req=4'b1011 held with distinct values → Grant sequence 0001, 0010, 1000, 0001; each grant interval = 32 + 10 cycles from capture to next capture; Digits track each value.
4. Release: Req drops to 0 during HOLD → HOLD completes, state IDLE, Grant=0, Digits retained, no extra Update; a later Req=4'b0100 → Grant=4'b0100.
5. Capture stability: Values changed mid-CONVERT → Digits reflect the captured value. A single persistent requester is recaptured each dwell, so the new value appears after the next conversion.
6. Reset: Rst_n low at CONVERT iteration 16 → Digits=32'hFFFF_FFFF, Grant=0 asynchronously, no Update. After release with Req=4'b1111 → first Grant=4'b0001.
